// File: rtl/down_count_timer_pkg.sv
// Shared definitions for the down-count timer: FSM states and default sizes.
package down_count_timer_pkg;

   localparam int DEF_WIDTH      = 4;
   localparam int DEF_PRESCALE_W = 4;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_PAUSE = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   // A state counts as "busy" while a count is in progress, paused or not.
   function automatic logic is_busy(input state_t s);
      return (s == ST_RUN) || (s == ST_PAUSE);
   endfunction

endpackage

// File: rtl/down_count_timer_if.sv
// Command/status bundle of the down-count timer.
// master drives the commands, slave is the timer itself.
interface down_count_timer_if
   import down_count_timer_pkg::*;
#(
   parameter int WIDTH      = DEF_WIDTH,
   parameter int PRESCALE_W = DEF_PRESCALE_W
);
   logic                  start;
   logic                  stop;
   logic                  pause;
   logic                  auto_reload;
   logic [WIDTH-1:0]      load_val;
   logic [PRESCALE_W-1:0] prescale;
   logic [WIDTH-1:0]      count;
   logic                  busy;
   logic                  done;
   logic                  tc_pulse;

   modport master (
      output start, stop, pause, auto_reload, load_val, prescale,
      input  count, busy, done, tc_pulse
   );

   modport slave (
      input  start, stop, pause, auto_reload, load_val, prescale,
      output count, busy, done, tc_pulse
   );
endinterface

// File: rtl/down_count_timer_tick_prescaler.sv
// Tick divider: while enabled, emits one tick every prescale+1 cycles.
module tick_prescaler #(
   parameter int PRESCALE_W = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  enable,
   input  logic                  clear,
   input  logic [PRESCALE_W-1:0] prescale,
   output logic                  tick
);

   logic [PRESCALE_W-1:0] pre_q;

   // The compare uses the live prescale input, so a new divider applies at the next compare.
   assign tick = enable && (pre_q == prescale);

   // Phase counter: cleared on command, wraps to 0 on each tick, frozen when disabled.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pre_q <= '0;
      end else if (clear) begin
         pre_q <= '0;
      end else if (enable) begin
         pre_q <= tick ? '0 : pre_q + 1'b1;
      end
   end

endmodule

// File: rtl/down_count_timer.sv
// Programmable down-count timer with prescaler, pause, one-shot and periodic modes.
module down_count_timer
   import down_count_timer_pkg::*;
#(
   parameter int WIDTH      = DEF_WIDTH,
   parameter int PRESCALE_W = DEF_PRESCALE_W
) (
   input logic               clk,
   input logic               rst,
   down_count_timer_if.slave bus
);

   state_t           state_q;
   logic [WIDTH-1:0] count_q;
   logic             tc_q;
   logic             run_step;
   logic             pre_clear;
   logic             tick;

   // A run step happens in RUN/PAUSE with pause low and no overriding command;
   // start and stop both restart the prescaler phase.
   always_comb begin
      pre_clear = bus.stop || bus.start;
      run_step  = is_busy(state_q) && !bus.pause && !pre_clear;
   end

   tick_prescaler #(
      .PRESCALE_W (PRESCALE_W)
   ) u_tick_prescaler (
      .clk      (clk),
      .rst      (rst),
      .enable   (run_step),
      .clear    (pre_clear),
      .prescale (bus.prescale),
      .tick     (tick)
   );

   // Control FSM: stop > start > pause; count and terminal-count strobe registered here.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= ST_IDLE;
         count_q <= '0;
         tc_q    <= 1'b0;
      end else begin
         tc_q <= 1'b0;
         if (bus.stop) begin
            state_q <= ST_IDLE;
            count_q <= '0;
         end else if (bus.start) begin
            count_q <= bus.load_val;
            if (bus.load_val == '0) begin
               // Nothing to count: finish immediately with a single strobe.
               state_q <= ST_DONE;
               tc_q    <= 1'b1;
            end else begin
               state_q <= ST_RUN;
            end
         end else begin
            case (state_q)
               ST_RUN, ST_PAUSE: begin
                  if (bus.pause) begin
                     state_q <= ST_PAUSE;
                  end else begin
                     state_q <= ST_RUN;
                     if (tick) begin
                        if (count_q > WIDTH'(1)) begin
                           count_q <= count_q - 1'b1;
                        end else begin
                           // Terminal tick; count 0 is treated like 1 so it can never wrap.
                           tc_q <= 1'b1;
                           if (bus.auto_reload && (bus.load_val != '0)) begin
                              count_q <= bus.load_val;
                           end else begin
                              count_q <= '0;
                              state_q <= ST_DONE;
                           end
                        end
                     end
                  end
               end
               default: begin
                  // IDLE and DONE hold their count and ignore pause.
                  state_q <= state_q;
               end
            endcase
         end
      end
   end

   assign bus.count    = count_q;
   assign bus.busy     = is_busy(state_q);
   assign bus.done     = (state_q == ST_DONE);
   assign bus.tc_pulse = tc_q;

endmodule
